mem_arbiter: RTL and testbench

- Shares the single 8-bit memory port (mem_clock / mem_write / address / to_mem / from_mem) between two requesters.
- Requester 0 is the control unit. Requester 1 is the program loader / I/O path.
- Sequences each access as a multi-cycle transaction and generates the registered mem_clock strobe that clocks mem.
- Arbitrates simultaneous requests round-robin.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one strobed 8-bit memory port between two requesters.
// Each access runs IDLE -> SETUP (SETUP_CYCLES) -> STROBE (mem_clock high) -> DONE (ack).
module mem_arbiter #(
    parameter int SETUP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       write0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic [7:0] rdata0,
    output logic       ack0,
    output logic       grant0,
    input  logic       req1,
    input  logic       write1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic [7:0] rdata1,
    output logic       ack1,
    output logic       grant1,
    output logic       mem_clock,
    output logic       mem_write,
    output logic [7:0] address,
    output logic [7:0] to_mem,
    input  logic [7:0] from_mem,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic last, last_n, sel;
    logic [7:0] address_n, to_mem_n, rdata0_n, rdata1_n;
    logic mem_write_n, mem_clock_n, grant0_n, grant1_n, ack0_n, ack1_n;

    // requester 1 wins when alone, or on a tie when requester 0 was served last
    assign sel = req1 & (~req0 | ~last);
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last_n = last;
        address_n = address;
        to_mem_n = to_mem;
        rdata0_n = rdata0;
        rdata1_n = rdata1;
        mem_write_n = mem_write;
        mem_clock_n = 1'b0;
        grant0_n = grant0;
        grant1_n = grant1;
        ack0_n = 1'b0;
        ack1_n = 1'b0;
        case (state)
            IDLE: if (req0 | req1) begin
                state_n = SETUP;
                cnt_n = 4'(SETUP_CYCLES);
                last_n = sel;
                grant0_n = ~sel;
                grant1_n = sel;
                address_n = sel ? addr1 : addr0;
                to_mem_n = sel ? wdata1 : wdata0;
                mem_write_n = sel ? write1 : write0;
            end
            SETUP: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = STROBE;
                    mem_clock_n = 1'b1;
                end
            end
            STROBE: begin
                state_n = DONE;
                mem_write_n = 1'b0;
                ack0_n = grant0;
                ack1_n = grant1;
                rdata0_n = (grant0 & ~mem_write) ? from_mem : rdata0;
                rdata1_n = (grant1 & ~mem_write) ? from_mem : rdata1;
            end
            default: begin
                state_n = IDLE;
                grant0_n = 1'b0;
                grant1_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            last <= 1'b1;
            address <= 8'd0;
            to_mem <= 8'd0;
            rdata0 <= 8'd0;
            rdata1 <= 8'd0;
            mem_write <= 1'b0;
            mem_clock <= 1'b0;
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last <= last_n;
            address <= address_n;
            to_mem <= to_mem_n;
            rdata0 <= rdata0_n;
            rdata1 <= rdata1_n;
            mem_write <= mem_write_n;
            mem_clock <= mem_clock_n;
            grant0 <= grant0_n;
            grant1 <= grant1_n;
            ack0 <= ack0_n;
            ack1 <= ack1_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (SETUP_CYCLES 1 and 3) on shared stimulus, each with its own memory
// and a timeline-based reference model, plus directed literal checks on the scenarios of interest.
module tb_mem_arbiter;
    logic clock = 0, reset = 0;
    logic req0 = 0, write0 = 0, req1 = 0, write1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [7:0] rdata0[2], rdata1[2], address[2], to_mem[2];
    logic ack0[2], ack1[2], grant0[2], grant1[2], mem_clock[2], mem_write[2], busy[2];
    int tests = 0, fails = 0;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int S = g ? 3 : 1;
        logic [7:0] mem[256];
        logic [7:0] mm[256];
        logic [7:0] fm = 0;
        bit act = 0, who = 0, wr = 0, last = 1;
        int age = 0;
        logic [7:0] ad = 0, wd = 0, e_addr = 0, e_tom = 0;
        logic [7:0] er[2] = '{8'd0, 8'd0};

        mem_arbiter #(.SETUP_CYCLES(S)) dut (
            .clock(clock), .reset(reset),
            .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
            .rdata0(rdata0[g]), .ack0(ack0[g]), .grant0(grant0[g]),
            .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
            .rdata1(rdata1[g]), .ack1(ack1[g]), .grant1(grant1[g]),
            .mem_clock(mem_clock[g]), .mem_write(mem_write[g]),
            .address(address[g]), .to_mem(to_mem[g]), .from_mem(fm), .busy(busy[g])
        );

        initial for (int i = 0; i < 256; i++) begin
            mem[i] = 0;
            mm[i] = 0;
        end

        always @(posedge mem_clock[g]) begin
            if (mem_write[g]) mem[address[g]] <= to_mem[g];
            fm <= mem[address[g]];
        end

        // reference: age counts edges since the grant edge; strobe at age S, ack at S+1, idle at S+2
        always @(posedge clock or posedge reset) begin
            if (reset) begin
                act = 0; last = 1; e_addr = 0; e_tom = 0; er[0] = 0; er[1] = 0;
            end else if (act) begin
                age++;
                if (age == S && wr) mm[ad] = wd;
                if (age == S + 1 && !wr) er[who] = mm[ad];
                if (age == S + 2) act = 0;
            end else if (req0 || req1) begin
                who = req1 && (!req0 || !last);
                last = who; act = 1; age = 0;
                wr = who ? write1 : write0;
                ad = who ? addr1 : addr0;
                wd = who ? wdata1 : wdata0;
                e_addr = ad; e_tom = wd;
            end
        end

        always @(negedge clock) begin
            chk($sformatf("i%0d busy", g), busy[g], act);
            chk($sformatf("i%0d grant0", g), grant0[g], act && !who);
            chk($sformatf("i%0d grant1", g), grant1[g], act && who);
            chk($sformatf("i%0d mem_clock", g), mem_clock[g], act && age == S);
            chk($sformatf("i%0d ack0", g), ack0[g], act && age == S + 1 && !who);
            chk($sformatf("i%0d ack1", g), ack1[g], act && age == S + 1 && who);
            chk($sformatf("i%0d mem_write", g), mem_write[g], act && wr && age <= S);
            chk($sformatf("i%0d address", g), address[g], e_addr);
            chk($sformatf("i%0d to_mem", g), to_mem[g], e_tom);
            chk($sformatf("i%0d rdata0", g), rdata0[g], er[0]);
            chk($sformatf("i%0d rdata1", g), rdata1[g], er[1]);
        end
    end

    task automatic wait_ack(input bit which, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(which ? ack1[0] : ack0[0]) && n < 40);
        if (!(which ? ack1[0] : ack0[0])) chk("ack timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy[0] || busy[1]) && n < 40);
        chk("idle timeout", busy[0] | busy[1], 0);
    endtask

    initial begin
        int n;
        bit order[$];
        #2 reset = 1;
        #1;
        chk("rst busy", busy[0], 0);
        chk("rst mem_clock", mem_clock[1], 0);
        chk("rst address", address[0], 0);
        repeat (2) @(negedge clock);
        reset = 0;
        repeat (3) @(negedge clock);
        chk("idle no strobe", mem_clock[0] | busy[0], 0);

        req0 = 1; write0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        @(negedge clock);
        chk("wr grant0", grant0[0], 1);
        chk("wr address", address[1], 8'h10);
        chk("wr to_mem", to_mem[0], 8'hA5);
        chk("wr mem_write", mem_write[0], 1);
        @(negedge clock);
        chk("wr strobe s1", mem_clock[0], 1);
        chk("wr no strobe s3", mem_clock[1], 0);
        @(negedge clock);
        chk("wr ack0 s1", ack0[0], 1);
        chk("wr grant1", grant1[0], 0);
        req0 = 0;
        @(negedge clock);
        chk("wr strobe s3", mem_clock[1], 1);
        @(negedge clock);
        chk("wr ack0 s3", ack0[1], 1);
        wait_idle();

        req0 = 1; write0 = 0; addr0 = 8'h10;
        wait_ack(0, n);
        chk("rd rdata0", rdata0[0], 8'hA5);
        chk("rd rdata1", rdata1[0], 0);
        req0 = 0;
        wait_idle();
        chk("rd rdata0 s3", rdata0[1], 8'hA5);

        @(negedge clock);
        #2 reset = 1;
        @(negedge clock);
        reset = 0;
        req0 = 1; write0 = 0; addr0 = 8'h10; req1 = 1; write1 = 0; addr1 = 8'h10;
        @(negedge clock);
        chk("tie grant0", grant0[0], 1);
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            @(negedge clock);
            if (ack0[0]) order.push_back(0);
            if (ack1[0]) order.push_back(1);
        end
        chk("tie count", order.size(), 6);
        for (int i = 0; i < order.size(); i++) chk($sformatf("tie order %0d", i), order[i], i % 2);
        req0 = 0; req1 = 0;
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            req1 = 1; write1 = 1; addr1 = 8'h20 + 8'(i); wdata1 = 8'(i + 1);
            wait_ack(1, n);
            if (i > 0) chk($sformatf("lone gap %0d", i), n, 4);
        end
        req1 = 0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            req0 = 1; write0 = 0; addr0 = 8'h20 + 8'(i);
            wait_ack(0, n);
            chk($sformatf("lone readback %0d", i), rdata0[0], i + 1);
        end
        req0 = 0;
        wait_idle();

        req0 = 1; write0 = 0; addr0 = 8'h10;
        for (int i = 0; i < 10 && !mem_clock[0]; i++) @(negedge clock);
        #2 reset = 1;
        #1;
        chk("strobe rst mem_clock", mem_clock[0], 0);
        chk("strobe rst grant0", grant0[0], 0);
        chk("strobe rst busy", busy[0], 0);
        chk("strobe rst ack0", ack0[0], 0);
        @(negedge clock);
        reset = 0;
        wait_ack(0, n);
        chk("after rst rdata0", rdata0[0], 8'hA5);
        req0 = 0;
        wait_idle();

        repeat (800) begin
            @(negedge clock);
            if (req0 ? ack0[0] : $urandom_range(3) == 0) begin
                req0 = $urandom_range(1); write0 = $urandom_range(1);
                addr0 = 8'($urandom_range(15)); wdata0 = 8'($urandom);
            end
            if (req1 ? ack1[0] : $urandom_range(3) == 0) begin
                req1 = $urandom_range(1); write1 = $urandom_range(1);
                addr1 = 8'($urandom_range(15)); wdata1 = 8'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        wait_idle();
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
